fpu_wb_buffer: RTL and testbench
================================

# fpu_wb_buffer

Result writeback buffer directly downstream of the FPU top level. It accepts each completed result, status and tag through a valid/ready handshake and holds up to DEPTH entries in order. It presents them first-word-fall-through to the core's floating-point writeback port. On retirement it ORs each entry's exception status into a sticky fflags register, so the FPU is not stalled by a busy register-file write port.

## Interface
- WIDTH, 64: result width; equals the FPU feature width.
- DEPTH, 4: entry count; power of two, ≥2.
- TagType, logic: tag type, passed through unchanged.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- flush_i  in  1  discard all buffered entries.
- result_i  in  WIDTH  FPU result.
- status_i  in  fpnew_pkg::status_t (5)  {NV,DZ,OF,UF,NX} of the result.
- tag_i  in  TagType  FPU tag.
- in_valid_i  in  1  FPU output valid.
- in_ready_o  out  1  buffer can accept; drives the FPU's out_ready_i.
- wb_result_o  out  WIDTH  head entry result.
- wb_status_o  out  5  head entry status.
- wb_tag_o  out  TagType  head entry tag.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback port consumes head.
- fflags_clr_i  in  1  clear sticky flags (CSR write).
- fflags_o  out  5  sticky accumulated flags.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- busy_o  out  1  count_o != 0.

## Operation
- Push when in_valid_i & in_ready_o. Entry {result, status, tag} is written at the write pointer.
- Pop when wb_valid_o & wb_ready_i. Read pointer advances.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - Empty: pointers fully equal.
  - Full: index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- in_ready_o = !full. It is independent of in_valid_i and wb_ready_i; there is no same-cycle pass-through when full.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Simultaneous push and pop when empty: push only, because wb_valid_o=0.
- flush_i has priority over push and pop. Next cycle both pointers and count are 0. Entry storage is untouched; fflags are not modified.
- Sticky flags (see Configuration):
  - fflags <= (fflags_clr_i ? 0 : fflags) | (pop ? head status : 0).
  - A clear and a pop in the same cycle leave exactly the popped status.
  - Flags are accumulated at pop, never at push. Flushed entries therefore never set flags.
- Storage holds no X: every entry is reset to 0. Head outputs show storage at the read pointer even when wb_valid_o=0.

## Timing
- Reset values:
  - in_ready_o=1, wb_valid_o=0, count_o=0, busy_o=0, fflags_o=0.
  - wb_result_o=0, wb_status_o=0, wb_tag_o='0.
- Push-to-wb_valid_o latency is 1 cycle (registered storage, no bypass).
- in_ready_o, wb_valid_o, count_o and busy_o are derived only from registered pointers; there are no combinational input-to-output paths on them.
- Head data changes only on the cycle after a pop, push-into-empty, flush, or reset.
- The writeback side holds wb_ready_i only as a function of its own state. The buffer keeps head data stable while wb_valid_o=1 and no pop occurs.
- Reset asserted mid-operation returns everything to reset values asynchronously; in-flight entries are lost.
- fflags_o is registered and visible one cycle after the pop or clear.

## Configuration
- FPU_WB_FFLAGS_EN defined: sticky fflags register implemented as above.
- Undefined:
  - No flags register.
  - fflags_o tied to 0.
  - fflags_clr_i ignored.
  - wb_status_o still carries per-entry status for the core to handle.

## Structure
- Status bit layout comes from fpnew_pkg::status_t; no new encodings.
- Entry struct {result, status, tag} is a local typedef, since it is parametric on WIDTH and TagType.
- The DEPTH-power-of-two check lives as an elaboration-time assertion.
- One sub-module, fpu_wb_fifo: the generic pointer/storage FIFO with flush.
- The top block adds the flags accumulator and the busy/count outputs.

## Test plan
- Reset, then push 4 entries (results 0x1..0x4, tags 0..3) with wb_ready_i=0:
  - count_o=4, in_ready_o=0, busy_o=1.
  - A 5th push is not accepted.
- From full, hold wb_ready_i=1 for 4 cycles: results 0x1..0x4 emerge in order, then wb_valid_o=0 and in_ready_o=1.
- Continuous push and pop with DEPTH=4 for 20 entries: no loss or duplication across pointer wrap, and count_o stays at 1.
- Flush with 3 entries while in_valid_i=1 in the same cycle: next cycle count_o=0 and wb_valid_o=0, the push is dropped, and fflags_o is unchanged.
- With FPU_WB_FFLAGS_EN, pop status NX (0x01) then DZ (0x08): fflags_o=0x09. Then assert fflags_clr_i while popping NV (0x10): fflags_o=0x10.
- With FPU_WB_FFLAGS_EN undefined, the same stimulus gives fflags_o=0 throughout and wb_status_o still 0x01, 0x08, 0x10.

Source files
------------

// File: rtl/fpu_wb_buffer_pkg.sv
// Shared types for the FPU writeback buffer.
// Exception status mirrors the fpnew status_t bit layout {NV,DZ,OF,UF,NX}, MSB first.
package fpu_wb_buffer_pkg;

   localparam int unsigned STATUS_W = 5;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   // Legal entry counts: powers of two, at least two
   function automatic bit depth_ok(int unsigned n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers and synchronous flush.
module fpu_wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type DataType = logic,
   localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  DataType          data_i,
   input  logic             push_i,
   output logic             ready_o,
   output DataType          data_o,
   output logic             valid_o,
   input  logic             pop_i,
   output logic             pop_o,
   output logic [PTR_W-1:0] count_o
);

   localparam int unsigned IDX_W = PTR_W - 1;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   DataType          mem_q [DEPTH];
   logic             full;
   logic             empty;
   logic             push;

   // Occupancy from registered pointers only
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

   // Flush overrides both sides of the handshake
   assign push  = push_i & ~full & ~flush_i;
   assign pop_o = pop_i & ~empty & ~flush_i;

   assign ready_o = ~full;
   assign valid_o = ~empty;
   assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
   assign count_o = wr_ptr_q - rd_ptr_q;

   // Pointer update; wrap bit makes full/empty distinguishable
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_o) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Entry storage; reset to zero so head outputs never show X
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/fpu_wb_buffer.sv
// FPU result writeback buffer: in-order FWFT queue plus sticky exception flags.
// Optional feature macro: FPU_WB_FFLAGS_EN (sticky fflags register; tied to 0 when undefined).
module fpu_wb_buffer
   import fpu_wb_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   parameter type TagType = logic,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic [WIDTH-1:0]    result_i,
   input  status_t             status_i,
   input  TagType              tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [WIDTH-1:0]    wb_result_o,
   output logic [STATUS_W-1:0] wb_status_o,
   output TagType              wb_tag_o,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   input  logic                fflags_clr_i,
   output logic [STATUS_W-1:0] fflags_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                busy_o
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      status_t          status;
      TagType           tag;
   } entry_t;

   // Reject illegal depths at elaboration
   if (!depth_ok(DEPTH)) begin : g_depth_check
      $error("fpu_wb_buffer: DEPTH must be a power of two and at least 2");
   end

   entry_t wr_entry;
   entry_t head;
   logic   pop;

   assign wr_entry = '{result: result_i, status: status_i, tag: tag_i};

   fpu_wb_fifo #(
      .DEPTH    (DEPTH),
      .DataType (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .data_i  (wr_entry),
      .push_i  (in_valid_i),
      .ready_o (in_ready_o),
      .data_o  (head),
      .valid_o (wb_valid_o),
      .pop_i   (wb_ready_i),
      .pop_o   (pop),
      .count_o (count_o)
   );

   assign wb_result_o = head.result;
   assign wb_status_o = head.status;
   assign wb_tag_o    = head.tag;
   assign busy_o      = (count_o != '0);

`ifdef FPU_WB_FFLAGS_EN
   logic [STATUS_W-1:0] fflags_q;

   // Accumulate status of retired entries; clear and pop together keep only the popped status
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= (fflags_clr_i ? '0 : fflags_q) | (pop ? wb_status_o : '0);
      end
   end

   assign fflags_o = fflags_q;
`else
   logic unused_fflags;

   // Flags handled by the core from per-entry status
   assign unused_fflags = fflags_clr_i ^ pop;
   assign fflags_o      = '0;
`endif

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Directed self-checking bench for fpu_wb_buffer (DEPTH=4, WIDTH=64, 4-bit tag).
module tb_fpu_wb_buffer;
   import fpu_wb_buffer_pkg::*;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;
   typedef logic [3:0] tag_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic [WIDTH-1:0]  result_i;
   status_t           status_i;
   tag_t              tag_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [WIDTH-1:0]  wb_result_o;
   logic [4:0]        wb_status_o;
   tag_t              wb_tag_o;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic              fflags_clr_i;
   logic [4:0]        fflags_o;
   logic [CNT_W-1:0]  count_o;
   logic              busy_o;

   int total = 0;
   int bad   = 0;

   fpu_wb_buffer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TagType (tag_t)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .result_i     (result_i),
      .status_i     (status_i),
      .tag_i        (tag_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .wb_result_o  (wb_result_o),
      .wb_status_o  (wb_status_o),
      .wb_tag_o     (wb_tag_o),
      .wb_valid_o   (wb_valid_o),
      .wb_ready_i   (wb_ready_i),
      .fflags_clr_i (fflags_clr_i),
      .fflags_o     (fflags_o),
      .count_o      (count_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs and checks happen 1ns after the rising edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [4:0] fl(input logic [4:0] v);
`ifdef FPU_WB_FFLAGS_EN
      return v;
`else
      return 5'h00;
`endif
   endfunction

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; result_i = '0; status_i = '0; tag_i = '0;
      in_valid_i = 1'b0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
      step(); step();

      // Reset values
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("rst_count",    64'(count_o),    64'd0);
      chk("rst_busy",     64'(busy_o),     64'd0);
      chk("rst_fflags",   64'(fflags_o),   64'd0);
      chk("rst_result",   wb_result_o,     64'd0);
      chk("rst_status",   64'(wb_status_o), 64'd0);
      chk("rst_tag",      64'(wb_tag_o),   64'd0);
      rst_ni = 1'b1;
      step();

      // Fill to full with the writeback side stalled
      for (int i = 0; i < 4; i++) begin
         in_valid_i = 1'b1; result_i = 64'(i + 1); tag_i = 4'(i);
         step();
         chk("fill_count", 64'(count_o), 64'(i + 1));
         chk("fill_head",  wb_result_o,  64'h1);
         chk("fill_valid", 64'(wb_valid_o), 64'd1);
      end
      chk("full_in_ready", 64'(in_ready_o), 64'd0);
      chk("full_busy",     64'(busy_o),     64'd1);
      result_i = 64'h99; tag_i = 4'hf;
      step();
      chk("full_reject_count", 64'(count_o), 64'd4);
      chk("full_reject_head",  wb_result_o,  64'h1);

      // Drain in order
      in_valid_i = 1'b0; wb_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid",  64'(wb_valid_o), 64'd1);
         chk("drain_result", wb_result_o,     64'(i + 1));
         chk("drain_tag",    64'(wb_tag_o),   64'(i));
         step();
      end
      chk("drain_empty_valid", 64'(wb_valid_o), 64'd0);
      chk("drain_in_ready",    64'(in_ready_o), 64'd1);
      chk("drain_count",       64'(count_o),    64'd0);

      // Streaming push/pop across pointer wrap
      in_valid_i = 1'b1; wb_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         result_i = 64'(100 + k); tag_i = 4'(k);
         step();
         chk("stream_count",  64'(count_o), 64'd1);
         chk("stream_result", wb_result_o,  64'(100 + k));
      end
      in_valid_i = 1'b0;
      step();
      chk("stream_end_count", 64'(count_o),    64'd0);
      chk("stream_end_valid", 64'(wb_valid_o), 64'd0);

      // Sticky flags: NX, DZ, then clear while popping NV
      wb_ready_i = 1'b0; in_valid_i = 1'b1;
      result_i = 64'hA; status_i = 5'h01; step();
      result_i = 64'hB; status_i = 5'h08; step();
      result_i = 64'hC; status_i = 5'h10; step();
      in_valid_i = 1'b0; status_i = '0; wb_ready_i = 1'b1;
      chk("flag_pre",     64'(fflags_o),    64'd0);
      chk("flag_st_nx",   64'(wb_status_o), 64'h01);
      step();
      chk("flag_after_nx", 64'(fflags_o),   64'(fl(5'h01)));
      chk("flag_st_dz",   64'(wb_status_o), 64'h08);
      step();
      chk("flag_after_dz", 64'(fflags_o),   64'(fl(5'h09)));
      chk("flag_st_nv",   64'(wb_status_o), 64'h10);
      chk("flag_res_nv",  wb_result_o,      64'hC);
      fflags_clr_i = 1'b1;
      step();
      fflags_clr_i = 1'b0; wb_ready_i = 1'b0;
      chk("flag_clr_pop",  64'(fflags_o),   64'(fl(5'h10)));
      chk("flag_empty",    64'(wb_valid_o), 64'd0);

      // Flush with 3 entries plus a same-cycle push and pop attempt
      in_valid_i = 1'b1; status_i = 5'h02;
      for (int i = 0; i < 3; i++) begin
         result_i = 64'(16'h200 + i); step();
      end
      chk("preflush_count", 64'(count_o), 64'd3);
      flush_i = 1'b1; wb_ready_i = 1'b1; result_i = 64'h77;
      step();
      flush_i = 1'b0; in_valid_i = 1'b0; wb_ready_i = 1'b0; status_i = '0;
      chk("flush_count",    64'(count_o),    64'd0);
      chk("flush_valid",    64'(wb_valid_o), 64'd0);
      chk("flush_in_ready", 64'(in_ready_o), 64'd1);
      chk("flush_busy",     64'(busy_o),     64'd0);
      chk("flush_fflags",   64'(fflags_o),   64'(fl(5'h10)));
      step();
      chk("flush_drop_count",  64'(count_o),  64'd0);
      chk("flush_drop_fflags", 64'(fflags_o), 64'(fl(5'h10)));

      // Asynchronous reset mid-operation
      in_valid_i = 1'b1; result_i = 64'h55; status_i = 5'h04;
      step(); step();
      in_valid_i = 1'b0;
      chk("prerst_count", 64'(count_o), 64'd2);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_count",  64'(count_o),    64'd0);
      chk("arst_valid",  64'(wb_valid_o), 64'd0);
      chk("arst_result", wb_result_o,     64'd0);
      chk("arst_fflags", 64'(fflags_o),   64'd0);
      step();
      rst_ni = 1'b1;
      step();
      chk("post_rst_ready", 64'(in_ready_o), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
